// File: rtl/i2c_cmd_sequencer.sv
`default_nettype none
// i2c_cmd_sequencer: buffers host I2C commands in a FIFO, issues them one at a time
// to the master driver over start/busy, and returns one response per command.
module i2c_cmd_sequencer #(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_rw,
  input  logic [6:0]             cmd_addr,
  input  logic [7:0]             cmd_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_rw,
  output logic [7:0]             rsp_rdata,
  output logic                   rsp_timeout,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   drv_start,
  output logic                   drv_rw,
  output logic [6:0]             drv_addr,
  output logic [7:0]             drv_wdata,
  input  logic                   drv_busy,
  input  logic [7:0]             drv_rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2,
    RESPOND   = 2'd3
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [15:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic            cmd_ready_q;
  logic            push, pop;
  logic [15:0]     head;

  logic            rsp_valid_q, rsp_rw_q, rsp_timeout_q;
  logic [7:0]      rsp_rdata_q;
  logic            drv_start_q, drv_rw_q;
  logic [6:0]      drv_addr_q;
  logic [7:0]      drv_wdata_q;

  assign push    = cmd_valid && cmd_ready_q;
  // Issue needs an idle driver and no unaccepted response outstanding.
  assign pop     = (state_q == IDLE) && (level_q != '0) && !drv_busy && !rsp_valid_q;
  assign head    = mem_q[rd_ptr_q];
  assign level_d = level_q + LW'(push) - LW'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_rw, cmd_addr, cmd_wdata};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      cmd_ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q     <= level_d;
      // Registered from the next level, so a push can never land on a full FIFO.
      cmd_ready_q <= (level_d != FULL_LVL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      drv_start_q   <= 1'b0;
      drv_rw_q      <= 1'b0;
      drv_addr_q    <= '0;
      drv_wdata_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rw_q      <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            drv_rw_q    <= head[15];
            drv_addr_q  <= head[14:8];
            drv_wdata_q <= head[7:0];
            drv_start_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (drv_busy) begin
            drv_start_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= WAIT_DONE;
          end else if (cnt_q == CNT_LAST) begin
            drv_start_q   <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rw_q      <= drv_rw_q;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b1;
            state_q       <= RESPOND;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WAIT_DONE: begin
          if (!drv_busy) begin
            rsp_valid_q   <= 1'b1;
            rsp_rw_q      <= drv_rw_q;
            rsp_rdata_q   <= drv_rw_q ? drv_rdata : 8'h00;
            rsp_timeout_q <= 1'b0;
            state_q       <= RESPOND;
          end else if (cnt_q == CNT_LAST) begin
            rsp_valid_q   <= 1'b1;
            rsp_rw_q      <= drv_rw_q;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b1;
            state_q       <= RESPOND;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESPOND: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign fifo_level  = level_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rw      = rsp_rw_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;
  assign drv_start   = drv_start_q;
  assign drv_rw      = drv_rw_q;
  assign drv_addr    = drv_addr_q;
  assign drv_wdata   = drv_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_cmd_sequencer.sv
`default_nettype none
// Bench for i2c_cmd_sequencer: directed vector table, corner-case sequences and a
// randomized run scored against a transaction-level model of the sequencer.
module tb_i2c_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int TO    = 8;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid, rsp_ready = 1'b0, rsp_rw, rsp_timeout;
  logic [7:0] rsp_rdata;
  logic [2:0] fifo_level;
  logic       drv_start, drv_rw, drv_busy;
  logic [6:0] drv_addr;
  logic [7:0] drv_wdata, drv_rdata = '0;
  logic       drv_busy_m = 1'b0, force_busy = 1'b0;

  assign drv_busy = drv_busy_m | force_busy;

  i2c_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rw(rsp_rw),
    .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout), .fifo_level(fifo_level),
    .drv_start(drv_start), .drv_rw(drv_rw), .drv_addr(drv_addr),
    .drv_wdata(drv_wdata), .drv_busy(drv_busy), .drv_rdata(drv_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic rw; logic [6:0] addr; logic [7:0] wdata; } cmd_t;
  typedef struct packed { logic rw; logic [7:0] rdata; logic to; } rsp_t;
  typedef struct {
    logic rw; logic [6:0] addr; logic [7:0] wd; int d; int h; logic [7:0] rd;
    logic e_rw; logic [7:0] e_rd; logic e_to;
  } vec_t;

  cmd_t model_q[$];
  rsp_t exp_q[$];
  int   nvec = 0, nmis = 0, resp_cnt = 0;
  bit   rand_drv = 0, rand_rdy = 0;
  int   cur_d = 0, cur_h = 1;
  logic [7:0] cur_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (rand_rdy) rsp_ready = ($urandom_range(3, 0) != 0);
  endtask

  task automatic push(input logic rw, input logic [6:0] a, input logic [7:0] wd,
                      input int maxw, output bit ok);
    cmd_t c;
    ok = 0;
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_wdata = wd;
    for (int i = 0; i < maxw; i++) begin
      if (cmd_ready) begin
        ok = 1; c.rw = rw; c.addr = a; c.wdata = wd;
        model_q.push_back(c);
      end
      tick();
      if (ok) break;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int maxc);
    bit got = 0;
    for (int i = 0; i < maxc; i++) begin
      if (rsp_valid) begin got = 1; break; end
      tick();
    end
    check("rsp_valid_within_bound", got, 1);
  endtask

  task automatic wait_drv_idle(input int maxc);
    for (int i = 0; i < maxc && drv_busy_m; i++) tick();
    check("driver_idle_within_bound", drv_busy_m, 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_rw"}, rsp_rw, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_rsp_timeout"}, rsp_timeout, 0);
    check({tag, "_drv_start"}, drv_start, 0);
    check({tag, "_drv_rw"}, drv_rw, 0);
    check({tag, "_drv_addr"}, drv_addr, 0);
    check({tag, "_drv_wdata"}, drv_wdata, 0);
    check({tag, "_fifo_level"}, fifo_level, 0);
  endtask

  // Driver model: reacts to start with a busy delay d and a busy length h.
  // Expected response follows from d/h alone: start timeout if d >= TO, done
  // timeout if busy is still high on the TO-th WAIT_DONE cycle (h > TO).
  int   dd, dh;
  logic [7:0] drd;
  cmd_t dc;
  rsp_t er;
  bit   dab;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rst_n && drv_start && !drv_busy_m) begin
        if (rand_drv) begin
          dd = $urandom_range(TO + 1, 0); dh = $urandom_range(TO + 2, 1); drd = 8'($urandom);
        end else begin
          dd = cur_d; dh = cur_h; drd = cur_rd;
        end
        check("issue_has_queued_cmd", (model_q.size() != 0), 1);
        if (model_q.size() != 0) begin
          dc = model_q.pop_front();
          check("drv_rw", drv_rw, dc.rw);
          check("drv_addr", drv_addr, dc.addr);
          if (!dc.rw) check("drv_wdata", drv_wdata, dc.wdata);
          er.rw    = dc.rw;
          er.to    = (dd >= TO) || (dh > TO);
          er.rdata = (er.to || !dc.rw) ? 8'h00 : drd;
          exp_q.push_back(er);
        end
        dab = 0;
        for (int i = 1; i <= dd; i++) begin
          @(posedge clk); #1;
          if (!drv_start) begin
            dab = 1;
            check("start_high_cycles", i, TO);
            break;
          end
        end
        if (!dab) begin
          drv_busy_m = 1'b1;
          drv_rdata  = ~drd;
          for (int i = 1; i <= dh; i++) begin
            @(posedge clk); #1;
            if (i == 1) check("start_drops_after_busy", drv_start, 0);
          end
          drv_rdata  = drd;
          drv_busy_m = 1'b0;
        end
      end
    end
  end

  // Response monitor: in-order scoreboard plus stability under backpressure.
  rsp_t held, mon_e;
  bit   hold_v = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v = 0;
      end else begin
        if (hold_v) begin
          check("hold_rsp_valid", rsp_valid, 1);
          check("hold_rsp_fields", {rsp_rw, rsp_rdata, rsp_timeout}, held);
          check("hold_no_start", drv_start, 0);
        end
        if (rsp_valid && rsp_ready) begin
          check("rsp_expected", (exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("rsp_rw", rsp_rw, mon_e.rw);
            check("rsp_rdata", rsp_rdata, mon_e.rdata);
            check("rsp_timeout", rsp_timeout, mon_e.to);
          end
          resp_cnt++;
          hold_v = 0;
        end else if (rsp_valid) begin
          hold_v = 1;
          held   = {rsp_rw, rsp_rdata, rsp_timeout};
        end else begin
          hold_v = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  vec_t tbl[8];
  bit   ok;
  int   acc, target, bad;

  initial begin
    tbl[0] = '{1'b0, 7'h50, 8'hA5, 3,   7,   8'h11, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 7'h3C, 8'h00, 1,   5,   8'h7E, 1'b1, 8'h7E, 1'b0};
    tbl[2] = '{1'b1, 7'h12, 8'h00, 0,   1,   8'hC3, 1'b1, 8'hC3, 1'b0};
    tbl[3] = '{1'b1, 7'h22, 8'h00, 7,   8,   8'h5A, 1'b1, 8'h5A, 1'b0};
    tbl[4] = '{1'b1, 7'h23, 8'h00, 8,   1,   8'h99, 1'b1, 8'h00, 1'b1};
    tbl[5] = '{1'b0, 7'h41, 8'h6D, 2,   9,   8'h77, 1'b0, 8'h00, 1'b1};
    tbl[6] = '{1'b1, 7'h05, 8'h00, 100, 1,   8'hEE, 1'b1, 8'h00, 1'b1};
    tbl[7] = '{1'b1, 7'h06, 8'h00, 0,   100, 8'hAB, 1'b1, 8'h00, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;
    tick();
    check("cmd_ready_after_reset", cmd_ready, 1);
    check("fifo_level_after_reset", fifo_level, 0);

    for (int v = 0; v < 8; v++) begin
      cur_d = tbl[v].d; cur_h = tbl[v].h; cur_rd = tbl[v].rd;
      push(tbl[v].rw, tbl[v].addr, tbl[v].wd, 200, ok);
      check("table_push", ok, 1);
      wait_rsp(300);
      check("table_rsp_rw", rsp_rw, tbl[v].e_rw);
      check("table_rsp_rdata", rsp_rdata, tbl[v].e_rd);
      check("table_rsp_timeout", rsp_timeout, tbl[v].e_to);
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    end
    wait_drv_idle(200);

    // Done timeout with response held off while a second command waits.
    cur_d = 0; cur_h = 10; cur_rd = 8'h00;
    push(1'b1, 7'h33, 8'h00, 20, ok);
    push(1'b0, 7'h44, 8'h5C, 20, ok);
    wait_rsp(100);
    check("bp_rsp_timeout", rsp_timeout, 1);
    check("bp_rsp_rdata", rsp_rdata, 0);
    cur_d = 1; cur_h = 2; cur_rd = 8'h3E;
    repeat (5) tick();
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 20 && !drv_start; i++) tick();
    check("bp_issue_resumes", drv_start, 1);
    wait_rsp(100);
    check("bp_second_rsp_timeout", rsp_timeout, 0);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    wait_drv_idle(100);

    // Fill the FIFO while a stale busy blocks issue, then drain with wrap.
    force_busy = 1'b1;
    tick();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      push(1'b0, 7'(8'h60 + i), 8'(i * 17), 1, ok);
      if (ok) acc++;
    end
    check("full_accepted", acc, DEPTH);
    check("full_level", fifo_level, DEPTH);
    check("full_cmd_ready", cmd_ready, 0);
    target = resp_cnt + 10;
    rand_drv = 1; rand_rdy = 1; force_busy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push(1'($urandom), 7'($urandom), 8'($urandom), 300, ok);
      check("wrap_push", ok, 1);
    end
    for (int i = 0; i < 2000 && resp_cnt < target; i++) tick();
    check("wrap_rsp_count", resp_cnt, target);

    // Randomized traffic.
    target = resp_cnt + 40;
    for (int n = 0; n < 40; n++) begin
      push(1'($urandom), 7'($urandom), 8'($urandom), 400, ok);
      check("rand_push", ok, 1);
      repeat ($urandom_range(3, 0)) tick();
    end
    for (int i = 0; i < 5000 && resp_cnt < target; i++) tick();
    check("rand_rsp_count", resp_cnt, target);
    check("rand_model_q_empty", model_q.size(), 0);
    check("rand_exp_q_empty", exp_q.size(), 0);
    rand_drv = 0; rand_rdy = 0; rsp_ready = 1'b0;
    wait_drv_idle(100);

    // Reset during WAIT_DONE with two commands still queued.
    cur_d = 1; cur_h = 60; cur_rd = 8'h42;
    for (int i = 0; i < 3; i++) push(1'b1, 7'(8'h10 + i), 8'h00, 20, ok);
    for (int i = 0; i < 20 && !drv_busy_m; i++) tick();
    repeat (3) tick();
    check("pre_reset_level", fifo_level, 2);
    rst_n = 1'b0;
    #1;
    check_reset("midreset");
    model_q.delete();
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (rsp_valid || drv_start) bad++;
    end
    check("no_activity_after_reset", bad, 0);
    check("level_after_reset_release", fifo_level, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
`default_nettype wire
